id_pipe: RTL and testbench
==========================

# id_pipe

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, operand forwarding, load-use stall generation and a valid/ready handshake on both sides. It sits between the IF/ID register and the execute stage. It decodes the logic, shift, LUI and LW subset, selects operands from the regfile or the forwarding paths, and presents registered micro-ops to EX.

## Interface
- `DATA_W`, 32: operand/data width.
- `ADDR_W`, 32: instruction address width.
- `RADDR_W`, 5: register address width.
- `ALUOP_W`, 8: aluop width.
- `ALUSEL_W`, 3: alusel width.

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `if_valid`  in  1  IF/ID holds an instruction
- `if_pc`  in  ADDR_W  instruction address
- `if_inst`  in  32  instruction word
- `id_ready`  out  1  ID accepts `if_inst` this cycle
- `reg1_read_o`, `reg2_read_o`  out  1  regfile read enables
- `reg1_addr_o`, `reg2_addr_o`  out  RADDR_W  regfile read addresses
- `reg1_data_i`, `reg2_data_i`  in  DATA_W  regfile read data (combinational)
- `ex_fwd_wreg`, `ex_fwd_wd`, `ex_fwd_wdata`, `ex_fwd_load`  in  1/RADDR_W/DATA_W/1  EX-stage write-back info; `ex_fwd_load`=1 means the data is not yet available
- `mem_fwd_wreg`, `mem_fwd_wd`, `mem_fwd_wdata`  in  1/RADDR_W/DATA_W  MEM-stage write-back info
- `flush`  in  1  kill the instruction in ID and in ID/EX
- `ex_ready`  in  1  EX accepts the ID/EX contents
- `ex_valid`, `ex_pc`, `aluop_o`, `alusel_o`, `reg1_o`, `reg2_o`, `wd_o`, `wreg_o`, `illegal_o`  out  registered ID/EX micro-op

## Operation
- Decode is combinational on `if_inst`, with op = [31:26] and funct = [5:0].
- ORI 001101, ANDI 001100, XORI 001110:
  - aluop OR 0x25 / AND 0x24 / XOR 0x26, alusel LOGIC 3'b001.
  - Reads rs; reg2 = zero-extended imm; wd = rt; wreg=1.
- LUI 001111:
  - aluop OR, alusel LOGIC.
  - reg1 = 0, no rs read; reg2 = {imm,16'b0}; wd = rt.
- SPECIAL 000000, logic group, funct 100100/100101/100110/100111:
  - aluop AND/OR/XOR/NOR (0x24/0x25/0x26/0x27), alusel LOGIC.
  - Reads rs and rt; wd = rd.
- SPECIAL 000000, shift group, funct 000000/000010/000011:
  - aluop SLL 0x7C / SRL 0x02 / SRA 0x03, alusel SHIFT 3'b010.
  - reg1 = zero-extended sa [10:6], no rs read; reads rt; wd = rd.
- LW 100011:
  - aluop 0xE3, alusel LOADSTORE 3'b111.
  - reg1 = rs; reg2 = sign-extended imm; wd = rt.
- Any other encoding: `illegal_o`=1, aluop 0, alusel 0, wreg=0.
- The all-zero word decodes as SLL $0, which is a legal NOP.
- Operand source per read port, in priority order:
  1. Address 0 → 0.
  2. EX match (`ex_fwd_wreg` && `ex_fwd_wd`==addr) → `ex_fwd_wdata`.
  3. MEM match → `mem_fwd_wdata`.
  4. Otherwise the regfile.
- Load-use stall: `if_valid` && `ex_fwd_load` && `ex_fwd_wreg` && `ex_fwd_wd`≠0 && `ex_fwd_wd` matches an enabled read address.
  - `id_ready`=0.
  - ID/EX loads a bubble (`ex_valid`=0) when `ex_ready`=1.
- `id_ready` = `ex_ready` && !stall.
- Read enables and addresses are driven even when `if_valid`=0 and are ignored then.

## Timing
- Reset (async):
  - `ex_valid`=0, `ex_pc`=0, aluop=0, alusel=0.
  - `reg1_o`=`reg2_o`=0, `wd_o`=0, `wreg_o`=0, `illegal_o`=0.
- Reset has no effect on the combinational outputs other than through the register state.
- Latency: an instruction accepted at edge N appears on the ID/EX outputs after edge N, so EX sees it in cycle N+1.
- Priority at each rising edge:
  1. `flush`: all ID/EX fields take their reset values. `id_ready` is forced to 1 that cycle, so the IF/ID entry is discarded.
  2. `ex_ready`=0: hold all ID/EX fields.
  3. Stall: load a bubble (`ex_valid`=0, `wreg_o`=0, other fields 0).
  4. `if_valid`: load the decoded micro-op with `ex_valid`=1.
  5. Otherwise: bubble.
- Handshake: a transfer occurs when `if_valid`&&`id_ready`. Upstream holds `if_inst` while `id_ready`=0.
- Simultaneous EX and MEM match on the same register: EX wins.
- A match from both stages during a load-use hazard still stalls.
- Reset mid-stall: the outputs clear immediately; after reset release, decode resumes when the stall condition has cleared.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all ID/EX outputs 0 before the next edge; `ex_valid`=0.
- ORI $2,$1,0x00FF with `reg1_data_i`=0x12340000, no forwarding → next cycle aluop 0x25, alusel 1, `reg1_o`=0x12340000, `reg2_o`=0x000000FF, `wd_o`=2, `wreg_o`=1.
- Forwarding: OR $3,$1,$2 with EX writing $1=0xAAAA0000 and MEM writing $1=0x1 and $2=0x5555 → `reg1_o`=0xAAAA0000, `reg2_o`=0x5555. Repeat with `ex_fwd_wd`=0 → `reg1_o` comes from the regfile, not EX.
- Load-use: `ex_fwd_load`=1, `ex_fwd_wd`=4, instruction AND $5,$4,$6 → `id_ready`=0 and `ex_valid`=0 next cycle. Drop `ex_fwd_load` → the instruction issues one cycle later.
- Backpressure and flush:
  - Hold `ex_ready`=0 for 3 cycles → outputs frozen and `id_ready`=0.
  - Assert `flush` together with a valid instruction → `ex_valid`=0 and `id_ready`=1.
- Illegal and shift:
  - Opcode 0x3F → `illegal_o`=1, `wreg_o`=0.
  - SRA $7,$8,5 with $8=0x80000000 → aluop 0x03, alusel 2, `reg1_o`=5, `reg2_o`=0x80000000.

Source files
------------

// File: rtl/id_pipe_if.sv
// Decode-stage interface: IF/ID handshake, regfile read port, forwarding
// inputs and the registered ID/EX micro-op.
interface id_pipe_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
);
    logic                if_valid;
    logic [ADDR_W-1:0]   if_pc;
    logic [31:0]         if_inst;
    logic                id_ready;

    logic                reg1_read_o;
    logic                reg2_read_o;
    logic [RADDR_W-1:0]  reg1_addr_o;
    logic [RADDR_W-1:0]  reg2_addr_o;
    logic [DATA_W-1:0]   reg1_data_i;
    logic [DATA_W-1:0]   reg2_data_i;

    logic                ex_fwd_wreg;
    logic [RADDR_W-1:0]  ex_fwd_wd;
    logic [DATA_W-1:0]   ex_fwd_wdata;
    logic                ex_fwd_load;
    logic                mem_fwd_wreg;
    logic [RADDR_W-1:0]  mem_fwd_wd;
    logic [DATA_W-1:0]   mem_fwd_wdata;

    logic                flush;
    logic                ex_ready;

    logic                ex_valid;
    logic [ADDR_W-1:0]   ex_pc;
    logic [ALUOP_W-1:0]  aluop_o;
    logic [ALUSEL_W-1:0] alusel_o;
    logic [DATA_W-1:0]   reg1_o;
    logic [DATA_W-1:0]   reg2_o;
    logic [RADDR_W-1:0]  wd_o;
    logic                wreg_o;
    logic                illegal_o;

    // Environment side: IF/ID, regfile, forwarding sources and EX
    modport master (
        output if_valid, if_pc, if_inst, reg1_data_i, reg2_data_i,
               ex_fwd_wreg, ex_fwd_wd, ex_fwd_wdata, ex_fwd_load,
               mem_fwd_wreg, mem_fwd_wd, mem_fwd_wdata, flush, ex_ready,
        input  id_ready, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
               ex_valid, ex_pc, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
               wreg_o, illegal_o
    );

    // Decode stage side
    modport slave (
        input  if_valid, if_pc, if_inst, reg1_data_i, reg2_data_i,
               ex_fwd_wreg, ex_fwd_wd, ex_fwd_wdata, ex_fwd_load,
               mem_fwd_wreg, mem_fwd_wd, mem_fwd_wdata, flush, ex_ready,
        output id_ready, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
               ex_valid, ex_pc, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
               wreg_o, illegal_o
    );
endinterface

// File: rtl/id_pipe.sv
// Instruction decode for the logic/shift/LUI/LW subset with operand
// forwarding, load-use stall and the ID/EX pipeline register.
module id_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input logic      clk,
    input logic      rst,
    id_pipe_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(8'h03);
    localparam logic [ALUOP_W-1:0] ALU_LW  = ALUOP_W'(8'hE3);

    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);
    localparam logic [ALUSEL_W-1:0] SEL_LDST  = ALUSEL_W'(3'b111);

    logic [5:0]          w_op, w_funct;
    logic [RADDR_W-1:0]  w_rs, w_rt, w_rd;
    logic [15:0]         w_imm;
    logic [4:0]          w_sa;

    logic [ALUOP_W-1:0]  w_aluop;
    logic [ALUSEL_W-1:0] w_alusel;
    logic                w_rd1, w_rd2;
    logic [DATA_W-1:0]   w_imm1, w_imm2;
    logic [RADDR_W-1:0]  w_wd;
    logic                w_wreg, w_illegal;
    logic [DATA_W-1:0]   w_op1, w_op2;
    logic                w_stall, w_take;

    logic                r_valid;
    logic [ADDR_W-1:0]   r_pc;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [ALUSEL_W-1:0] r_alusel;
    logic [DATA_W-1:0]   r_reg1, r_reg2;
    logic [RADDR_W-1:0]  r_wd;
    logic                r_wreg, r_illegal;

    assign w_op    = bus.if_inst[31:26];
    assign w_funct = bus.if_inst[5:0];
    assign w_rs    = RADDR_W'(bus.if_inst[25:21]);
    assign w_rt    = RADDR_W'(bus.if_inst[20:16]);
    assign w_rd    = RADDR_W'(bus.if_inst[15:11]);
    assign w_sa    = bus.if_inst[10:6];
    assign w_imm   = bus.if_inst[15:0];

    // Instruction decode; operands not taken from the regfile come from w_imm1/w_imm2
    always_comb begin
        w_aluop   = '0;
        w_alusel  = '0;
        w_rd1     = 1'b0;
        w_rd2     = 1'b0;
        w_imm1    = '0;
        w_imm2    = '0;
        w_wd      = '0;
        w_wreg    = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                w_aluop  = (w_op == OP_ORI) ? ALU_OR : (w_op == OP_ANDI) ? ALU_AND : ALU_XOR;
                w_alusel = SEL_LOGIC;
                w_rd1    = 1'b1;
                w_imm2   = DATA_W'(w_imm);
                w_wd     = w_rt;
                w_wreg   = 1'b1;
            end
            OP_LUI: begin
                w_aluop  = ALU_OR;
                w_alusel = SEL_LOGIC;
                w_imm2   = DATA_W'({w_imm, 16'h0000});
                w_wd     = w_rt;
                w_wreg   = 1'b1;
            end
            OP_LW: begin
                w_aluop  = ALU_LW;
                w_alusel = SEL_LDST;
                w_rd1    = 1'b1;
                w_imm2   = {{(DATA_W-16){w_imm[15]}}, w_imm};
                w_wd     = w_rt;
                w_wreg   = 1'b1;
            end
            OP_SPECIAL: begin
                w_wd   = w_rd;
                w_wreg = 1'b1;
                case (w_funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        w_aluop  = (w_funct == FN_AND) ? ALU_AND :
                                   (w_funct == FN_OR)  ? ALU_OR  :
                                   (w_funct == FN_XOR) ? ALU_XOR : ALU_NOR;
                        w_alusel = SEL_LOGIC;
                        w_rd1    = 1'b1;
                        w_rd2    = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_aluop  = (w_funct == FN_SLL) ? ALU_SLL :
                                   (w_funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                        w_alusel = SEL_SHIFT;
                        w_rd2    = 1'b1;
                        w_imm1   = DATA_W'(w_sa);
                    end
                    default: begin
                        w_wd      = '0;
                        w_wreg    = 1'b0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Operand 1 source: $0, then EX, then MEM, then regfile
    always_comb begin
        if (!w_rd1)                                             w_op1 = w_imm1;
        else if (w_rs == '0)                                    w_op1 = '0;
        else if (bus.ex_fwd_wreg && (bus.ex_fwd_wd == w_rs))    w_op1 = bus.ex_fwd_wdata;
        else if (bus.mem_fwd_wreg && (bus.mem_fwd_wd == w_rs))  w_op1 = bus.mem_fwd_wdata;
        else                                                    w_op1 = bus.reg1_data_i;
    end

    // Operand 2 source: same priority as operand 1
    always_comb begin
        if (!w_rd2)                                             w_op2 = w_imm2;
        else if (w_rt == '0)                                    w_op2 = '0;
        else if (bus.ex_fwd_wreg && (bus.ex_fwd_wd == w_rt))    w_op2 = bus.ex_fwd_wdata;
        else if (bus.mem_fwd_wreg && (bus.mem_fwd_wd == w_rt))  w_op2 = bus.mem_fwd_wdata;
        else                                                    w_op2 = bus.reg2_data_i;
    end

    // A load still in EX cannot be forwarded, so a dependent instruction must wait
    assign w_stall = bus.if_valid && bus.ex_fwd_load && bus.ex_fwd_wreg &&
                     (bus.ex_fwd_wd != '0) &&
                     ((w_rd1 && (bus.ex_fwd_wd == w_rs)) || (w_rd2 && (bus.ex_fwd_wd == w_rt)));
    assign w_take  = bus.if_valid && !w_stall;

    assign bus.id_ready    = bus.flush || (bus.ex_ready && !w_stall);
    assign bus.reg1_read_o = w_rd1;
    assign bus.reg2_read_o = w_rd2;
    assign bus.reg1_addr_o = w_rs;
    assign bus.reg2_addr_o = w_rt;

    // ID/EX register: flush clears, EX backpressure holds, otherwise load micro-op or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_aluop   <= '0;
            r_alusel  <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.ex_ready) begin
            r_valid   <= w_take;
            r_pc      <= w_take ? bus.if_pc : '0;
            r_aluop   <= w_take ? w_aluop   : '0;
            r_alusel  <= w_take ? w_alusel  : '0;
            r_reg1    <= w_take ? w_op1     : '0;
            r_reg2    <= w_take ? w_op2     : '0;
            r_wd      <= w_take ? w_wd      : '0;
            r_wreg    <= w_take && w_wreg;
            r_illegal <= w_take && w_illegal;
        end
    end

    assign bus.ex_valid  = r_valid;
    assign bus.ex_pc     = r_pc;
    assign bus.aluop_o   = r_aluop;
    assign bus.alusel_o  = r_alusel;
    assign bus.reg1_o    = r_reg1;
    assign bus.reg2_o    = r_reg2;
    assign bus.wd_o      = r_wd;
    assign bus.wreg_o    = r_wreg;
    assign bus.illegal_o = r_illegal;
endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: decode/forwarding model plus a
// scoreboard queue of expected ID/EX micro-ops.
module tb_id_pipe;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        ill;
    } uop_t;

    logic        clk;
    logic        rst;
    logic [31:0] rf [32];
    uop_t        q [$];
    bit          m_valid;
    bit          acc;
    int          n_vec;
    int          n_miss;

    id_pipe_if #(.DATA_W(32), .ADDR_W(32), .RADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3)) bus ();

    id_pipe #(.DATA_W(32), .ADDR_W(32), .RADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.reg1_data_i = rf[bus.reg1_addr_o];
    assign bus.reg2_data_i = rf[bus.reg2_addr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] m_src(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.ex_fwd_wreg && bus.ex_fwd_wd == a) return bus.ex_fwd_wdata;
        if (bus.mem_fwd_wreg && bus.mem_fwd_wd == a) return bus.mem_fwd_wdata;
        return rf[a];
    endfunction

    function automatic void m_decode(input logic [31:0] inst, input logic [31:0] pc,
                                     output uop_t u, output bit r1, output bit r2);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11]; imm = inst[15:0];
        u = '0; u.pc = pc; r1 = 0; r2 = 0;
        case (inst[31:26])
            6'h0D: begin u.aluop = 8'h25; u.alusel = 3'd1; r1 = 1; u.r1 = m_src(rs); u.r2 = {16'h0, imm}; u.wd = rt; u.wreg = 1; end
            6'h0C: begin u.aluop = 8'h24; u.alusel = 3'd1; r1 = 1; u.r1 = m_src(rs); u.r2 = {16'h0, imm}; u.wd = rt; u.wreg = 1; end
            6'h0E: begin u.aluop = 8'h26; u.alusel = 3'd1; r1 = 1; u.r1 = m_src(rs); u.r2 = {16'h0, imm}; u.wd = rt; u.wreg = 1; end
            6'h0F: begin u.aluop = 8'h25; u.alusel = 3'd1; u.r2 = {imm, 16'h0}; u.wd = rt; u.wreg = 1; end
            6'h23: begin u.aluop = 8'hE3; u.alusel = 3'd7; r1 = 1; u.r1 = m_src(rs); u.r2 = {{16{imm[15]}}, imm}; u.wd = rt; u.wreg = 1; end
            6'h00: begin
                case (inst[5:0])
                    6'h24: u.aluop = 8'h24;
                    6'h25: u.aluop = 8'h25;
                    6'h26: u.aluop = 8'h26;
                    6'h27: u.aluop = 8'h27;
                    6'h00: u.aluop = 8'h7C;
                    6'h02: u.aluop = 8'h02;
                    6'h03: u.aluop = 8'h03;
                    default: u.ill = 1;
                endcase
                if (!u.ill) begin
                    u.wd = rd; u.wreg = 1; r2 = 1; u.r2 = m_src(rt);
                    if (inst[5]) begin u.alusel = 3'd1; r1 = 1; u.r1 = m_src(rs); end
                    else begin u.alusel = 3'd2; u.r1 = {27'h0, inst[10:6]}; end
                end
            end
            default: u.ill = 1;
        endcase
    endfunction

    task automatic cmp_uop(input uop_t e);
        chk("ex_pc", bus.ex_pc, e.pc);
        chk("aluop", {24'h0, bus.aluop_o}, {24'h0, e.aluop});
        chk("alusel", {29'h0, bus.alusel_o}, {29'h0, e.alusel});
        chk("reg1", bus.reg1_o, e.r1);
        chk("reg2", bus.reg2_o, e.r2);
        chk("wd", {27'h0, bus.wd_o}, {27'h0, e.wd});
        chk("wreg", {31'h0, bus.wreg_o}, {31'h0, e.wreg});
        chk("illegal", {31'h0, bus.illegal_o}, {31'h0, e.ill});
    endtask

    // One clock: check current state, update model/scoreboard, advance to next negedge
    task automatic cycle(output bit accepted);
        uop_t u;
        bit   r1, r2, st, rdy;
        #1;
        m_decode(bus.if_inst, bus.if_pc, u, r1, r2);
        st  = bus.if_valid && bus.ex_fwd_load && bus.ex_fwd_wreg && (bus.ex_fwd_wd != 0) &&
              ((r1 && bus.ex_fwd_wd == bus.if_inst[25:21]) || (r2 && bus.ex_fwd_wd == bus.if_inst[20:16]));
        rdy = bus.flush || (bus.ex_ready && !st);
        chk("id_ready", {31'h0, bus.id_ready}, {31'h0, rdy});
        chk("rd1_en", {31'h0, bus.reg1_read_o}, {31'h0, r1});
        chk("rd2_en", {31'h0, bus.reg2_read_o}, {31'h0, r2});
        if (r1) chk("rd1_addr", {27'h0, bus.reg1_addr_o}, {27'h0, bus.if_inst[25:21]});
        if (r2) chk("rd2_addr", {27'h0, bus.reg2_addr_o}, {27'h0, bus.if_inst[20:16]});
        chk("ex_valid", {31'h0, bus.ex_valid}, {31'h0, m_valid});
        if (m_valid) begin
            cmp_uop(q[0]);
            if (bus.flush || bus.ex_ready) void'(q.pop_front());
        end else begin
            chk("bubble_wreg", {31'h0, bus.wreg_o}, 32'h0);
            chk("bubble_aluop", {24'h0, bus.aluop_o}, 32'h0);
        end
        accepted = bus.if_valid && rdy;
        if (bus.flush) m_valid = 0;
        else if (bus.ex_ready) begin
            if (bus.if_valid && !st) begin
                m_valid = 1;
                q.push_back(u);
            end else m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] inst);
        bus.if_valid = 1'b1;
        bus.if_inst  = inst;
        bus.if_pc    = bus.if_pc + 32'd4;
        cycle(acc);
    endtask

    task automatic idle(input int n);
        bus.if_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic clear_fwd();
        bus.ex_fwd_wreg = 0; bus.ex_fwd_wd = '0; bus.ex_fwd_wdata = '0; bus.ex_fwd_load = 0;
        bus.mem_fwd_wreg = 0; bus.mem_fwd_wd = '0; bus.mem_fwd_wdata = '0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge
    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        chk("rst_ex_valid", {31'h0, bus.ex_valid}, 32'h0);
        chk("rst_ex_pc", bus.ex_pc, 32'h0);
        chk("rst_aluop", {24'h0, bus.aluop_o}, 32'h0);
        chk("rst_reg1", bus.reg1_o, 32'h0);
        chk("rst_reg2", bus.reg2_o, 32'h0);
        chk("rst_wd", {27'h0, bus.wd_o}, 32'h0);
        chk("rst_wreg", {31'h0, bus.wreg_o}, 32'h0);
        q.delete();
        m_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7)); sa = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 13))
            0:  return enc_i(6'h0D, rs, rt, imm);
            1:  return enc_i(6'h0C, rs, rt, imm);
            2:  return enc_i(6'h0E, rs, rt, imm);
            3:  return enc_i(6'h0F, rs, rt, imm);
            4:  return enc_i(6'h23, rs, rt, imm);
            5:  return enc_r(rs, rt, rd, 5'd0, 6'h24);
            6:  return enc_r(rs, rt, rd, 5'd0, 6'h25);
            7:  return enc_r(rs, rt, rd, 5'd0, 6'h26);
            8:  return enc_r(rs, rt, rd, 5'd0, 6'h27);
            9:  return enc_r(5'd0, rt, rd, sa, 6'h00);
            10: return enc_r(5'd0, rt, rd, sa, 6'h02);
            11: return enc_r(5'd0, rt, rd, sa, 6'h03);
            12: return enc_i(6'h3F, rs, rt, imm);
            default: return enc_r(rs, rt, rd, 5'd0, 6'h20);
        endcase
    endfunction

    initial begin
        n_vec = 0; n_miss = 0; m_valid = 0;
        rst = 1'b1;
        bus.if_valid = 0; bus.if_pc = '0; bus.if_inst = '0;
        bus.flush = 0; bus.ex_ready = 1;
        clear_fwd();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEADBEEF; rf[1] = 32'h12340000; rf[2] = 32'h00002222;
        rf[8] = 32'h80000000;
        @(negedge clk); @(negedge clk);
        #1;
        chk("init_ex_valid", {31'h0, bus.ex_valid}, 32'h0);
        chk("init_ex_pc", bus.ex_pc, 32'h0);
        chk("init_alusel", {29'h0, bus.alusel_o}, 32'h0);
        chk("init_illegal", {31'h0, bus.illegal_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ORI $2,$1,0x00FF
        issue(enc_i(6'h0D, 5'd1, 5'd2, 16'h00FF));
        chk("ori_aluop", {24'h0, bus.aluop_o}, 32'h25);
        chk("ori_alusel", {29'h0, bus.alusel_o}, 32'h1);
        chk("ori_reg1", bus.reg1_o, 32'h12340000);
        chk("ori_reg2", bus.reg2_o, 32'h000000FF);
        chk("ori_wd", {27'h0, bus.wd_o}, 32'd2);
        chk("ori_wreg", {31'h0, bus.wreg_o}, 32'h1);
        idle(1);

        // Forwarding: EX beats MEM on $1; MEM supplies $2; EX to $0 ignored
        bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 5'd1; bus.ex_fwd_wdata = 32'hAAAA0000;
        bus.mem_fwd_wreg = 1; bus.mem_fwd_wd = 5'd1; bus.mem_fwd_wdata = 32'h1;
        issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25));
        chk("fwd_ex_over_mem", bus.reg1_o, 32'hAAAA0000);
        chk("fwd_rf_reg2", bus.reg2_o, 32'h00002222);
        bus.mem_fwd_wd = 5'd2; bus.mem_fwd_wdata = 32'h5555;
        issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25));
        chk("fwd_ex_reg1", bus.reg1_o, 32'hAAAA0000);
        chk("fwd_mem_reg2", bus.reg2_o, 32'h5555);
        bus.ex_fwd_wd = 5'd0;
        issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25));
        chk("fwd_ex_r0_reg1", bus.reg1_o, 32'h12340000);
        // $0 read returns zero even when EX targets $0 and regfile holds junk
        bus.ex_fwd_load = 1;
        issue(enc_r(5'd0, 5'd2, 5'd3, 5'd0, 6'h25));
        chk("r0_zero", bus.reg1_o, 32'h0);
        chk("r0_no_stall", {31'h0, bus.ex_valid}, 32'h1);
        clear_fwd();

        // Load-use stall on $4, then release
        bus.ex_fwd_load = 1; bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 5'd4; bus.ex_fwd_wdata = 32'h0F0F0F0F;
        bus.mem_fwd_wreg = 1; bus.mem_fwd_wd = 5'd4; bus.mem_fwd_wdata = 32'h3;
        issue(enc_r(5'd4, 5'd6, 5'd5, 5'd0, 6'h24));
        chk("stall_bubble", {31'h0, bus.ex_valid}, 32'h0);
        cycle(acc);
        chk("stall_hold_acc", {31'h0, acc}, 32'h0);
        bus.ex_fwd_load = 0;
        cycle(acc);
        chk("stall_release", {31'h0, bus.ex_valid}, 32'h1);
        chk("stall_fwd_reg1", bus.reg1_o, 32'h0F0F0F0F);
        clear_fwd();

        // Backpressure: three cycles of ex_ready=0 with a pending instruction
        issue(enc_i(6'h0E, 5'd3, 5'd9, 16'h1234));
        bus.ex_ready = 0;
        bus.if_inst = enc_i(6'h0C, 5'd9, 5'd10, 16'hFFFF);
        bus.if_pc = bus.if_pc + 32'd4;
        for (int i = 0; i < 3; i++) cycle(acc);
        chk("bp_aluop", {24'h0, bus.aluop_o}, 32'h26);
        chk("bp_reg2", bus.reg2_o, 32'h1234);
        bus.ex_ready = 1;
        cycle(acc);
        idle(1);

        // Flush with a valid instruction in ID and one in ID/EX
        issue(enc_i(6'h0D, 5'd1, 5'd11, 16'h0001));
        bus.flush = 1;
        issue(enc_i(6'h0D, 5'd1, 5'd12, 16'h0002));
        bus.flush = 0;
        chk("flush_valid", {31'h0, bus.ex_valid}, 32'h0);

        // Illegal encodings and remaining formats
        issue(enc_i(6'h3F, 5'd1, 5'd2, 16'h0));
        chk("ill_flag", {31'h0, bus.illegal_o}, 32'h1);
        chk("ill_wreg", {31'h0, bus.wreg_o}, 32'h0);
        issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        issue(enc_r(5'd0, 5'd8, 5'd7, 5'd5, 6'h03));
        chk("sra_aluop", {24'h0, bus.aluop_o}, 32'h03);
        chk("sra_alusel", {29'h0, bus.alusel_o}, 32'h2);
        chk("sra_reg1", bus.reg1_o, 32'd5);
        chk("sra_reg2", bus.reg2_o, 32'h80000000);
        issue(32'h0);
        chk("nop_illegal", {31'h0, bus.illegal_o}, 32'h0);
        issue(enc_i(6'h0F, 5'd1, 5'd13, 16'hBEEF));
        chk("lui_reg2", bus.reg2_o, 32'hBEEF0000);
        chk("lui_reg1", bus.reg1_o, 32'h0);
        issue(enc_i(6'h23, 5'd1, 5'd14, 16'hFFF0));
        chk("lw_reg2", bus.reg2_o, 32'hFFFFFFF0);
        issue(enc_r(5'd1, 5'd2, 5'd15, 5'd0, 6'h27));
        idle(1);

        // Asynchronous reset with a valid micro-op in ID/EX
        issue(enc_i(6'h0D, 5'd1, 5'd2, 16'h0042));
        reset_mid();
        idle(1);

        // Reset during a load-use stall; decode resumes once the hazard clears
        bus.ex_fwd_load = 1; bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 5'd4; bus.ex_fwd_wdata = 32'h77;
        issue(enc_r(5'd1, 5'd4, 5'd5, 5'd0, 6'h26));
        reset_mid();
        cycle(acc);
        bus.ex_fwd_load = 0;
        cycle(acc);
        chk("rst_stall_resume", bus.reg2_o, 32'h77);
        clear_fwd();
        idle(1);

        // Random traffic honouring the upstream hold rule
        acc = 1;
        for (int i = 0; i < 300; i++) begin
            if (acc || !bus.if_valid) begin
                bus.if_valid = ($urandom_range(0, 3) != 0);
                bus.if_inst  = rand_inst();
                bus.if_pc    = bus.if_pc + 32'd4;
            end
            bus.ex_fwd_wreg   = 1'($urandom_range(0, 1));
            bus.ex_fwd_wd     = 5'($urandom_range(0, 7));
            bus.ex_fwd_wdata  = $urandom;
            bus.ex_fwd_load   = ($urandom_range(0, 3) == 0);
            bus.mem_fwd_wreg  = 1'($urandom_range(0, 1));
            bus.mem_fwd_wd    = 5'($urandom_range(0, 7));
            bus.mem_fwd_wdata = $urandom;
            bus.ex_ready      = ($urandom_range(0, 3) != 0);
            bus.flush         = ($urandom_range(0, 15) == 0);
            cycle(acc);
        end
        clear_fwd();
        bus.flush = 0;
        bus.ex_ready = 1;
        idle(3);
        chk("sb_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
